// File: rtl/id_hazard_controller.sv
// Decode-stage hazard controller: shadows the destinations of the instructions in EX/MEM/WB,
// raises a stall on RAW hits against the ID sources, and flushes on a taken branch.
module id_hazard_controller #(
    parameter int FORWARD_EN = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [3:0]           id_src1,
    input  logic [3:0]           id_src2,
    input  logic                 id_two_src,
    input  logic                 id_wb_en,
    input  logic                 id_mem_read,
    input  logic [3:0]           id_dst,
    input  logic                 branch_taken,
    output logic                 hazard_stall,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] stall_count
);
    localparam int SLOT_W   = 6;
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    // slot layout: {valid, dst[3:0], is_load}
    logic [SLOT_W-1:0]    slot_q [3];
    logic [SLOT_W-1:0]    slot_d [3];
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic [CNT_WIDTH-1:0] stall_count_d;
    logic                 ex_hit;
    logic                 mem_hit;
    logic                 raw_stall;

    function automatic logic slot_hit(input logic [SLOT_W-1:0] slot,
                                      input logic [3:0] src1,
                                      input logic [3:0] src2,
                                      input logic two_src);
        return slot[5] && ((slot[4:1] == src1) || (two_src && (slot[4:1] == src2)));
    endfunction

    always_comb begin
        ex_hit  = slot_hit(slot_q[SLOT_EX], id_src1, id_src2, id_two_src);
        mem_hit = slot_hit(slot_q[SLOT_MEM], id_src1, id_src2, id_two_src);
        if (FORWARD_EN != 0) begin
            raw_stall = id_valid && ex_hit && slot_q[SLOT_EX][0];
        end else begin
            raw_stall = id_valid && (ex_hit || mem_hit);
        end
        // A taken branch squashes the stalled instruction, so flush wins.
        flush        = branch_taken;
        hazard_stall = raw_stall && !branch_taken;
    end

    always_comb begin
        slot_d[SLOT_WB]  = slot_q[SLOT_MEM];
        slot_d[SLOT_MEM] = slot_q[SLOT_EX];
        slot_d[SLOT_EX]  = '0;
        if (id_valid && id_wb_en && !hazard_stall && !branch_taken) begin
            slot_d[SLOT_EX] = {1'b1, id_dst, id_mem_read};
        end
        stall_count_d = stall_count_q;
        if (hazard_stall && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                slot_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                slot_q[i] <= slot_d[i];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
endmodule
